// File: rtl/line_buf_pkg.sv
// Shared constants and helpers for the line window buffer.
package line_buf_pkg;

    // Pixel width, image dimension and tap count limits
    localparam int DATA_W_MIN    = 1;
    localparam int IMG_DIM_MIN   = 2;
    localparam int IMG_DIM_MAX   = 2048;
    localparam int NUM_LINES_MIN = 2;
    localparam int NUM_LINES_MAX = 8;

    // Border handling encodings
    localparam int BORDER_SUPPRESS  = 0;
    localparam int BORDER_ZERO_FILL = 1;

    // Bits needed to index 'value' entries; never returns less than 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/line_window_buffer_line_ram.sv
// Simple dual-port line store: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old word.
module line_ram
    import line_buf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 250,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Vertical line window: presents NUM_LINES pixels of one column (current row
// and the rows above it) two cycles after each accepted raster-order pixel.
// Line stores form a cascade; store k holds row (current-1-k).
module line_window_buffer
    import line_buf_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 250,
    parameter int IMG_H       = 250,
    parameter int NUM_LINES   = 3,
    parameter int BORDER_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic [NUM_LINES*DATA_W-1:0]   taps,
    output logic                          taps_valid,
    output logic [clog2(IMG_W)-1:0]       col_out,
    output logic [clog2(IMG_H)-1:0]       row_out,
    output logic                          frame_done
);

    localparam int COL_W  = clog2(IMG_W);
    localparam int ROW_W  = clog2(IMG_H);
    localparam int NSTORE = NUM_LINES - 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Zero a tap slice whose source row lies above the top of the frame
    function automatic logic [DATA_W-1:0] border_mask(
        input logic [DATA_W-1:0] pix,
        input logic [ROW_W-1:0]  row,
        input int                k
    );
        logic [DATA_W-1:0] res;
        res = pix;
        if (32'(row) < 32'(k)) begin
            res = '0;
        end
        return res;
    endfunction

    // Raster write position
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;

    // Position of the pixel presented this cycle; frame_start takes effect first
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic             row_ok;

    assign pix_col = frame_start ? '0 : wr_col;
    assign pix_row = frame_start ? '0 : wr_row;

    // Suppress mode only qualifies rows that have a full column of history
    assign row_ok = (BORDER_MODE == BORDER_ZERO_FILL) ||
                    (32'(pix_row) >= 32'(NUM_LINES - 1));

    // Raster position counters: column wraps into row, row wraps into a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_col <= '0;
            wr_row <= '0;
        end else if (din_valid) begin
            if (pix_col == COL_LAST) begin
                wr_col <= '0;
                wr_row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                wr_col <= pix_col + 1'b1;
                wr_row <= pix_row;
            end
        end else if (frame_start) begin
            wr_col <= '0;
            wr_row <= '0;
        end
    end

    // ---------------- stage p0: pixel captured, line stores read ----------------
    logic              acc_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] din_p0;
    logic [COL_W-1:0]  col_p0;
    logic [ROW_W-1:0]  row_p0;

    // Control for stage p0: acc_p0 drives the cascade write, vld_p0 the qualifier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_p0 <= 1'b0;
            vld_p0 <= 1'b0;
        end else begin
            acc_p0 <= din_valid;
            vld_p0 <= din_valid && row_ok;
        end
    end

    // Data for stage p0; held while no pixel arrives
    always_ff @(posedge clk) begin
        if (din_valid) begin
            din_p0 <= din;
            col_p0 <= pix_col;
            row_p0 <= pix_row;
        end
    end

    // Line store read data after any forwarding
    logic [DATA_W-1:0] ram_q  [NSTORE];
    logic [DATA_W-1:0] rd_val [NSTORE];

    genvar k;
    for (k = 0; k < NSTORE; k++) begin : g_store
        logic              st_wr_en;
        logic [COL_W-1:0]  st_wr_addr;
        logic [DATA_W-1:0] st_wr_data;

        if (k == 0) begin : g_head
            // Store 0 is read and written in the same cycle; the RAM returns the old row
            assign st_wr_en   = din_valid;
            assign st_wr_addr = pix_col;
            assign st_wr_data = din;
            assign rd_val[k]  = ram_q[k];
        end else begin : g_tail
            logic              fwd_vld;
            logic [DATA_W-1:0] fwd_data;

            // Store k takes store k-1's old word one cycle after acceptance
            assign st_wr_en   = acc_p0;
            assign st_wr_addr = col_p0;
            assign st_wr_data = rd_val[k-1];

            // A frame_start can make the next read hit the column still being
            // written by the delayed cascade; flag it so the new word is used
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fwd_vld <= 1'b0;
                end else if (din_valid) begin
                    fwd_vld <= acc_p0 && (col_p0 == pix_col);
                end
            end

            // Forwarded word captured alongside the colliding read
            always_ff @(posedge clk) begin
                if (din_valid) begin
                    fwd_data <= rd_val[k-1];
                end
            end

            assign rd_val[k] = fwd_vld ? fwd_data : ram_q[k];
        end

        line_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W),
            .ADDR_W (COL_W)
        ) u_line_ram (
            .clk     (clk),
            .wr_en   (st_wr_en),
            .wr_addr (st_wr_addr),
            .wr_data (st_wr_data),
            .rd_en   (din_valid),
            .rd_addr (pix_col),
            .rd_data (ram_q[k])
        );
    end

    // Assemble the window; slices above the frame top are forced to zero
    logic [NUM_LINES*DATA_W-1:0] taps_nxt;

    always_comb begin
        taps_nxt            = '0;
        taps_nxt[DATA_W-1:0] = din_p0;
        for (int i = 1; i < NUM_LINES; i++) begin
            taps_nxt[i*DATA_W +: DATA_W] = border_mask(rd_val[i-1], row_p0, i);
        end
    end

    // ---------------- stage p1: registered window and qualifiers ----------------
    // frame_start kills the pixel still in flight; taps and position hold without a pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps       <= '0;
            taps_valid <= 1'b0;
            frame_done <= 1'b0;
            col_out    <= '0;
            row_out    <= '0;
        end else begin
            taps_valid <= vld_p0 && !frame_start;
            frame_done <= vld_p0 && !frame_start &&
                          (col_p0 == COL_LAST) && (row_p0 == ROW_LAST);
            if (acc_p0) begin
                taps    <= taps_nxt;
                col_out <= col_p0;
                row_out <= row_p0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: two instances (suppress / zero-fill borders)
// share stimulus and are compared against an image-array reference model.
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_start = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;

    logic [NL*DW-1:0] taps0, taps1;
    logic             tv0, tv1, fd0, fd1;
    logic [1:0]       co0, co1, ro0, ro1;

    always #5 clk = ~clk;

    line_window_buffer #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .NUM_LINES(NL), .BORDER_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .din(din),
        .din_valid(din_valid), .taps(taps0), .taps_valid(tv0),
        .col_out(co0), .row_out(ro0), .frame_done(fd0)
    );

    line_window_buffer #(
        .DATA_W(DW), .IMG_W(W), .IMG_H(H), .NUM_LINES(NL), .BORDER_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .din(din),
        .din_valid(din_valid), .taps(taps1), .taps_valid(tv1),
        .col_out(co1), .row_out(ro1), .frame_done(fd1)
    );

    // Expected output for one input cycle
    typedef struct {
        bit          acc;
        bit          vld;
        bit          done;
        bit          tchk;
        logic [23:0] taps;
        int          col;
        int          row;
    } rec_t;

    rec_t        pipe [2][2];   // [mode][age]: age 0 = previous input, age 1 = two back
    int          pix  [H][W];   // pixels of the current frame by (row, col)
    int          m_col, m_row;
    logic [23:0] last_taps [2];
    int          last_col  [2];
    int          last_row  [2];
    bit          last_ok   [2];

    int n_vec, n_err;

    // Per-phase observations
    int          cnt_v [2];
    int          cnt_d [2];
    bit          seen  [2];
    logic [23:0] first_taps [2];
    int          first_row  [2];
    logic [23:0] done_taps  [2];
    logic [23:0] r1c2_taps  [2];
    logic [23:0] r2c0_taps  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        for (int m = 0; m < 2; m++) begin
            cnt_v[m] = 0; cnt_d[m] = 0; seen[m] = 1'b0;
            first_taps[m] = 'x; first_row[m] = -1; done_taps[m] = 'x;
            r1c2_taps[m] = 'x; r2c0_taps[m] = 'x;
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 2; a++) begin
                pipe[m][a].acc  = 1'b0;
                pipe[m][a].vld  = 1'b0;
                pipe[m][a].done = 1'b0;
                pipe[m][a].tchk = (m == 1);
                pipe[m][a].taps = '0;
                pipe[m][a].col  = 0;
                pipe[m][a].row  = 0;
            end
            last_taps[m] = '0;
            last_col[m]  = 0;
            last_row[m]  = 0;
            last_ok[m]   = (m == 1);
        end
    endtask

    task automatic check_dut(input int m, input logic tv, input logic fd,
                             input logic [23:0] tp, input logic [1:0] co, input logic [1:0] ro);
        rec_t r;
        r = pipe[m][1];
        chk($sformatf("m%0d_taps_valid", m), 32'(tv), 32'(r.vld));
        chk($sformatf("m%0d_frame_done", m), 32'(fd), 32'(r.done));
        if (r.tchk) begin
            chk($sformatf("m%0d_taps", m), 32'(tp), 32'(r.taps));
            chk($sformatf("m%0d_col_out", m), 32'(co), 32'(r.col));
            chk($sformatf("m%0d_row_out", m), 32'(ro), 32'(r.row));
        end
        if (tv) begin
            cnt_v[m]++;
            if (!seen[m]) begin
                seen[m] = 1'b1;
                first_taps[m] = tp;
                first_row[m] = int'(ro);
            end
            if (ro == 2'd1 && co == 2'd2) r1c2_taps[m] = tp;
            if (ro == 2'd2 && co == 2'd0) r2c0_taps[m] = tp;
        end
        if (fd) begin
            cnt_d[m]++;
            done_taps[m] = tp;
        end
    endtask

    // One clock: check outputs due now, then drive the next input and predict it
    task automatic step(input bit dv, input bit fs, input bit use_rc);
        rec_t        r;
        logic [7:0]  d;
        logic [23:0] t;
        bit          v;
        @(negedge clk);
        check_dut(0, tv0, fd0, taps0, co0, ro0);
        check_dut(1, tv1, fd1, taps1, co1, ro1);
        for (int m = 0; m < 2; m++) pipe[m][1] = pipe[m][0];
        if (fs) begin
            m_col = 0;
            m_row = 0;
            for (int m = 0; m < 2; m++) begin
                if (pipe[m][1].acc) begin
                    pipe[m][1].vld  = 1'b0;
                    pipe[m][1].done = 1'b0;
                    pipe[m][1].tchk = 1'b0;
                    last_ok[m] = 1'b0;
                end
            end
        end
        d = use_rc ? 8'(m_row * 16 + m_col) : 8'($urandom);
        if (dv) begin
            pix[m_row][m_col] = int'(d);
            t = '0;
            for (int k = 0; k < NL; k++) begin
                if (m_row >= k) t[k*8 +: 8] = 8'(pix[m_row-k][m_col]);
            end
            for (int m = 0; m < 2; m++) begin
                v = (m == 1) || (m_row >= NL - 1);
                r.acc  = 1'b1;
                r.vld  = v;
                r.done = v && (m_row == H - 1) && (m_col == W - 1);
                r.tchk = (m == 1) ? 1'b1 : v;
                r.taps = t;
                r.col  = m_col;
                r.row  = m_row;
                pipe[m][0] = r;
                last_taps[m] = t;
                last_col[m]  = m_col;
                last_row[m]  = m_row;
                last_ok[m]   = 1'b1;
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                r.acc  = 1'b0;
                r.vld  = 1'b0;
                r.done = 1'b0;
                r.tchk = (m == 1) && last_ok[m];
                r.taps = last_taps[m];
                r.col  = last_col[m];
                r.row  = last_row[m];
                pipe[m][0] = r;
            end
        end
        din         = d;
        din_valid   = dv;
        frame_start = fs;
    endtask

    // Asynchronous reset in mid-cycle; outputs must clear before the next edge
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst         = 1'b1;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        #1;
        chk("rst_taps0", 32'(taps0), 32'h0);
        chk("rst_valid0", 32'(tv0), 32'h0);
        chk("rst_done0", 32'(fd0), 32'h0);
        chk("rst_col0", 32'(co0), 32'h0);
        chk("rst_row0", 32'(ro0), 32'h0);
        chk("rst_taps1", 32'(taps1), 32'h0);
        chk("rst_valid1", 32'(tv1), 32'h0);
        chk("rst_done1", 32'(fd1), 32'h0);
        chk("rst_col1", 32'(co1), 32'h0);
        chk("rst_row1", 32'(ro1), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic frame_summary(input string tag);
        chk({tag, "_nvalid0"}, 32'(cnt_v[0]), 32'd8);
        chk({tag, "_nvalid1"}, 32'(cnt_v[1]), 32'd16);
        chk({tag, "_ndone0"}, 32'(cnt_d[0]), 32'd1);
        chk({tag, "_ndone1"}, 32'(cnt_d[1]), 32'd1);
        chk({tag, "_first_taps0"}, 32'(first_taps[0]), 32'h001020);
        chk({tag, "_first_row0"}, 32'(first_row[0]), 32'd2);
        chk({tag, "_done_taps0"}, 32'(done_taps[0]), 32'h132333);
        chk({tag, "_done_taps1"}, 32'(done_taps[1]), 32'h132333);
        chk({tag, "_r1c2_taps1"}, 32'(r1c2_taps[1]), 32'h000212);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        clr_mon();
        repeat (2) @(negedge clk);
        do_reset();

        // Continuous frame
        clr_mon();
        repeat (16) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        frame_summary("cont");

        // Gapped input: one pixel then two idle cycles
        clr_mon();
        for (int i = 0; i < 46; i++) step((i % 3) == 0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        frame_summary("gap");

        // Back-to-back frames: random content first, then the reference pattern
        clr_mon();
        repeat (16) step(1'b1, 1'b0, 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("b2b_ndone0", 32'(cnt_d[0]), 32'd2);
        chk("b2b_ndone1", 32'(cnt_d[1]), 32'd2);
        chk("b2b_nvalid0", 32'(cnt_v[0]), 32'd16);
        chk("b2b_second_r2c0", 32'(r2c0_taps[0]), 32'h001020);

        // frame_start together with pixel (2,1)
        clr_mon();
        repeat (9) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("fs_nvalid0", 32'(cnt_v[0]), 32'd8);
        chk("fs_nvalid1", 32'(cnt_v[1]), 32'd24);
        chk("fs_ndone0", 32'(cnt_d[0]), 32'd1);
        chk("fs_first_row0", 32'(first_row[0]), 32'd2);
        chk("fs_first_taps0", 32'(first_taps[0]), 32'h001020);

        // Reset during row 3, then a full frame
        repeat (14) step(1'b1, 1'b0, 1'b1);
        do_reset();
        clr_mon();
        repeat (16) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        frame_summary("rst");

        // Random traffic with occasional frame_start and reset
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2, 1'b0);
            end
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 250, meaning pixels per line (legal range 2..2048).
REQ-003 SHALL have parameter IMG_H, default 250, meaning lines per frame (legal range 2..2048).
REQ-004 SHALL have parameter NUM_LINES, default 3, meaning vertical taps including the current row (legal range 2..8).
REQ-005 SHALL have parameter BORDER_MODE, default 0, meaning 0 = suppress rows lacking history and 1 = zero-fill missing rows.
REQ-006 SHALL have port clk, input, width 1: the only clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-008 SHALL have port frame_start, input, width 1: synchronous frame clear.
REQ-009 SHALL have port din, input, width DATA_W: pixel in raster order.
REQ-010 SHALL have port din_valid, input, width 1: pixel write strobe; no backpressure exists.
REQ-011 SHALL have port taps, output, width NUM_LINES*DATA_W: slice k (bits k*DATA_W upward) holds pixel (row-k, col).
REQ-012 SHALL have port taps_valid, output, width 1: taps qualifier.
REQ-013 SHALL have port col_out, output, width clog2(IMG_W): column of the current taps.
REQ-014 SHALL have port row_out, output, width clog2(IMG_H): row of the current taps.
REQ-015 SHALL have port frame_done, output, width 1: one-cycle pulse coincident with the taps of pixel (IMG_H-1, IMG_W-1).

Function
REQ-016 SHALL keep a write column counter that advances on each din_valid and wraps from IMG_W-1 to 0, incrementing the row counter on wrap.
REQ-017 SHALL wrap the row counter from IMG_H-1 to 0, with the next pixel treated as (0,0) of a new frame.
REQ-018 SHALL store NUM_LINES-1 previous lines, each IMG_W deep, in cascade: each accepted pixel reads every line store at col, writes din to store 0, and writes store k-1's old value to store k (read-before-write).
REQ-019 SHALL present taps, taps_valid, col_out and row_out exactly 2 cycles after the accepted din_valid, at a fixed latency independent of gaps in din_valid.
REQ-020 SHALL, with BORDER_MODE=0, assert taps_valid only for pixels with row >= NUM_LINES-1.
REQ-021 SHALL, with BORDER_MODE=1, assert taps_valid for every accepted pixel and force slice k to zero where row < k.
REQ-022 SHALL, when din_valid is low, deassert taps_valid 2 cycles later and hold taps unchanged.
REQ-023 SHALL, on frame_start, clear the column and row counters and kill in-flight pipeline valids (taps_valid=0 for the next 2 cycles except for pixels accepted after the clear); line-store contents are not cleared.
REQ-024 SHALL, when frame_start and din_valid are high in the same cycle, apply the clear first and accept that pixel as (0,0).
REQ-025 SHALL assert frame_done only when taps_valid is also high for (IMG_H-1, IMG_W-1), irrespective of BORDER_MODE.

Reset
REQ-026 SHALL, on asserted rst, immediately drive taps_valid=0, frame_done=0, taps=0, col_out=0 and row_out=0, and clear the counters and pipeline valids.
REQ-027 SHALL leave line-store contents undefined after rst; no output may expose them before they are rewritten in the current frame.
REQ-028 SHALL, on rst asserted mid-frame, discard that frame; the first pixel after release is (0,0).

Structure
REQ-029 SHALL take its shared constants (width limits, NUM_LINES limit, BORDER_MODE encodings) and a clog2 function from package line_buf_pkg.
REQ-030 SHALL implement each line store as sub-module line_ram, a simple dual-port RAM (DATA_W x IMG_W, 1-cycle registered read, no reset), instantiated NUM_LINES-1 times.

Verification (DATA_W=8, IMG_W=4, IMG_H=4, NUM_LINES=3, din=row*16+col unless stated)
REQ-031 SHALL cover a continuous frame with BORDER_MODE=0: the first taps_valid occurs 2 cycles after pixel (2,0), with taps slices = {0x00,0x10,0x20} for k=2,1,0; exactly 8 valids; frame_done coincides with slices {0x13,0x23,0x33}.
REQ-032 SHALL cover BORDER_MODE=1: pixel (1,2) yields slices {0x00,0x02,0x12}, and 16 valids are produced.
REQ-033 SHALL cover gapped input (din_valid 1-0-0-1 pattern): the output sequence is identical to the continuous case, and each valid lags its input by exactly 2 cycles.
REQ-034 SHALL cover frame_start asserted with din_valid at pixel (2,1): no taps_valid for the old frame after the clear, and the next frame restarts at (0,0) with no valid before row 2 in BORDER_MODE=0.
REQ-035 SHALL cover rst pulsed mid-row 3: outputs go to zero asynchronously, and after release a full frame reproduces the REQ-031 results.
REQ-036 SHALL cover back-to-back frames: frame_done pulses once per frame, and the second frame's first valid taps are slices {0x00,0x10,0x20} with no stale data.
